// File: rtl/pwm_cfg_uart.sv
// +----------------------------------------------------------------------------+
// | pwm_cfg_uart : 8N1 UART command receiver driving PWM generator config.      |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_cfg_uart #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int DEF_FREQ     = 50,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        pwm_en,
    output logic [31:0] pwm_frequency,
    output logic [7:0]  duty_cycle,
    output logic        cfg_ok,
    output logic        frame_err
);
    localparam int          DIV     = CLK_FREQ / BAUD;
    localparam int          HALF    = DIV / 2;
    localparam int          TMO_CYC = TIMEOUT_BITS * DIV;
    localparam int          BW      = $clog2(DIV + 1);
    localparam int          TW      = $clog2(TMO_CYC + 1);
    localparam logic [31:0] FMAX    = 32'(CLK_FREQ / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_SYNC, P_CMD, P_PAY, P_CHK, P_EXEC} p_state_e;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    rx_state_e       rx_state_q, rx_state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_stb, stop_err;

    p_state_e        p_state_q, p_state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [31:0]     pay_q, pay_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            timeout;
    logic            err_d, wr_freq, wr_duty, wr_en;

    logic            pwm_en_q, restart_q, cfg_ok_q, frame_err_q;
    logic [31:0]     freq_q;
    logic [7:0]      duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            bcnt_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            bcnt_q     <= bcnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        bcnt_d     = bcnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        stop_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                bcnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit is a line glitch.
                if (bcnt_q == BW'(HALF - 1)) begin
                    bcnt_d     = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bcnt_q == BW'(DIV - 1)) begin
                    bcnt_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bcnt_q == BW'(DIV - 1)) begin
                    bcnt_d     = '0;
                    rx_state_d = RX_IDLE;
                    byte_stb   = rx_sync_q;
                    stop_err   = ~rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q <= P_SYNC;
            cmd_q     <= '0;
            pay_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
        end else begin
            p_state_q <= p_state_d;
            cmd_q     <= cmd_d;
            pay_q     <= pay_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
        end
    end

    assign timeout = (p_state_q == P_CMD || p_state_q == P_PAY || p_state_q == P_CHK)
                     && !byte_stb && (tmo_q == TW'(TMO_CYC - 1));

    always_comb begin
        p_state_d = p_state_q;
        cmd_d     = cmd_q;
        pay_d     = pay_q;
        idx_d     = idx_q;
        tmo_d     = (p_state_q == P_SYNC || byte_stb) ? '0 : tmo_q + 1'b1;
        err_d     = 1'b0;
        wr_freq   = 1'b0;
        wr_duty   = 1'b0;
        wr_en     = 1'b0;
        case (p_state_q)
            P_SYNC: if (byte_stb && shift_q == 8'hA5) p_state_d = P_CMD;
            P_CMD: begin
                if (byte_stb) begin
                    cmd_d     = shift_q;
                    idx_d     = '0;
                    p_state_d = P_PAY;
                end
            end
            P_PAY: begin
                // Bytes arrive P0 first, so shifting in from the top yields {P3,P2,P1,P0}.
                if (byte_stb) begin
                    pay_d = {shift_q, pay_q[31:8]};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) p_state_d = P_CHK;
                end
            end
            P_CHK: begin
                if (byte_stb) begin
                    if (shift_q == (cmd_q ^ pay_q[7:0] ^ pay_q[15:8] ^ pay_q[23:16] ^ pay_q[31:24])) begin
                        p_state_d = P_EXEC;
                    end else begin
                        err_d     = 1'b1;
                        p_state_d = P_SYNC;
                    end
                end
            end
            P_EXEC: begin
                p_state_d = P_SYNC;
                case (cmd_q)
                    8'h01: begin
                        if (pay_q != '0 && pay_q <= FMAX) wr_freq = 1'b1;
                        else err_d = 1'b1;
                    end
                    8'h02: begin
                        if (pay_q[7:0] <= 8'd100) wr_duty = 1'b1;
                        else err_d = 1'b1;
                    end
                    8'h03:   wr_en = 1'b1;
                    default: err_d = 1'b1;
                endcase
            end
            default: p_state_d = P_SYNC;
        endcase
        if (stop_err || timeout) begin
            err_d     = 1'b1;
            p_state_d = P_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_en_q    <= 1'b0;
            restart_q   <= 1'b0;
            freq_q      <= 32'(DEF_FREQ);
            duty_q      <= '0;
            cfg_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cfg_ok_q    <= wr_freq | wr_duty | wr_en;
            frame_err_q <= err_d;
            restart_q   <= 1'b0;
            if (wr_freq) freq_q <= pay_q;
            if (wr_duty) duty_q <= pay_q[7:0];
            // The generator latches period/duty only on a pwm_en rise, so force one low cycle.
            if ((wr_freq || wr_duty) && pwm_en_q) begin
                pwm_en_q  <= 1'b0;
                restart_q <= 1'b1;
            end else if (restart_q) begin
                pwm_en_q  <= 1'b1;
            end else if (wr_en) begin
                pwm_en_q  <= pay_q[0];
            end
        end
    end

    assign pwm_en        = pwm_en_q;
    assign pwm_frequency = freq_q;
    assign duty_cycle    = duty_q;
    assign cfg_ok        = cfg_ok_q;
    assign frame_err     = frame_err_q;

    a_no_stb_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
        !(p_state_q == P_EXEC && (byte_stb || stop_err)));

endmodule

`default_nettype wire

// File: tb/tb_pwm_cfg_uart.sv
// +----------------------------------------------------------------------------+
// | tb_pwm_cfg_uart : directed plus random frames against a frame-level model.  |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pwm_cfg_uart;
    localparam int          CLK_FREQ = 1600000;
    localparam int          BAUD     = 100000;
    localparam int          DEF_FREQ = 50;
    localparam int          TMO_BITS = 40;
    localparam int          BITC     = CLK_FREQ / BAUD;
    localparam logic [31:0] FMAX     = CLK_FREQ / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        pwm_en;
    logic [31:0] pwm_frequency;
    logic [7:0]  duty_cycle;
    logic        cfg_ok;
    logic        frame_err;

    pwm_cfg_uart #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEF_FREQ(DEF_FREQ), .TIMEOUT_BITS(TMO_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .pwm_en(pwm_en),
        .pwm_frequency(pwm_frequency), .duty_cycle(duty_cycle),
        .cfg_ok(cfg_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Event monitor: pulse counts, one-cycle enable drops and illegal value changes.
    int          n_ok = 0, n_err = 0, n_pulse = 0, n_bad_chg = 0, low_len = 0;
    logic [31:0] pulse_freq = '0, fq_prev = '0;
    logic [7:0]  pulse_duty = '0, dc_prev = '0;
    logic        en_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
            low_len = 0;
        end else begin
            if (cfg_ok) n_ok++;
            if (frame_err) n_err++;
            if ((pwm_frequency !== fq_prev || duty_cycle !== dc_prev) && !cfg_ok) n_bad_chg++;
            if (en_prev && !pwm_en) begin
                low_len    = 1;
                pulse_freq = pwm_frequency;
                pulse_duty = duty_cycle;
            end else if (!pwm_en && low_len > 0) begin
                low_len++;
            end else if (!en_prev && pwm_en) begin
                if (low_len == 1) n_pulse++;
                low_len = 0;
            end
            en_prev = pwm_en;
        end
        fq_prev = pwm_frequency;
        dc_prev = duty_cycle;
    end

    logic        m_en;
    logic [31:0] m_freq;
    logic [7:0]  m_duty;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BITC);
        end
        uart_rx = stop;
        tick(BITC);
        uart_rx = 1'b1;
        tick(2 * BITC);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".en"},   {31'd0, pwm_en}, {31'd0, m_en});
        check({tag, ".freq"}, pwm_frequency,   m_freq);
        check({tag, ".duty"}, {24'd0, duty_cycle}, {24'd0, m_duty});
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] p,
                             input logic [7:0] chk);
        int ok0, err0, pul0, bad0, e_ok, e_err, e_pulse;
        ok0 = n_ok; err0 = n_err; pul0 = n_pulse; bad0 = n_bad_chg;
        send_byte(8'hA5, 1'b1);
        send_byte(cmd, 1'b1);
        send_byte(p[7:0], 1'b1);
        send_byte(p[15:8], 1'b1);
        send_byte(p[23:16], 1'b1);
        send_byte(p[31:24], 1'b1);
        send_byte(chk, 1'b1);
        tick(40);
        e_ok = 0; e_err = 0; e_pulse = 0;
        if (chk != (cmd ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24])) begin
            e_err = 1;
        end else if (cmd == 8'h01) begin
            if (p >= 1 && p <= FMAX) begin
                e_ok = 1; e_pulse = m_en ? 1 : 0; m_freq = p;
            end else e_err = 1;
        end else if (cmd == 8'h02) begin
            if (p[7:0] <= 8'd100) begin
                e_ok = 1; e_pulse = m_en ? 1 : 0; m_duty = p[7:0];
            end else e_err = 1;
        end else if (cmd == 8'h03) begin
            e_ok = 1; m_en = p[0];
        end else begin
            e_err = 1;
        end
        check({tag, ".cfg_ok"},    n_ok - ok0,      e_ok);
        check({tag, ".frame_err"}, n_err - err0,    e_err);
        check({tag, ".restart"},   n_pulse - pul0,  e_pulse);
        check({tag, ".stable"},    n_bad_chg - bad0, 0);
        if (e_pulse == 1) begin
            check({tag, ".pulse_freq"}, pulse_freq, m_freq);
            check({tag, ".pulse_duty"}, {24'd0, pulse_duty}, {24'd0, m_duty});
        end
        check_outputs(tag);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] cmd, input logic [31:0] p);
        return cmd ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24];
    endfunction

    initial begin
        int ok0, err0;
        logic [7:0]  cmd, chk;
        logic [31:0] p;
        m_en = 1'b0; m_freq = DEF_FREQ; m_duty = 8'd0;

        tick(5);
        check_outputs("reset");
        check("reset.cfg_ok", {31'd0, cfg_ok}, 0);
        check("reset.frame_err", {31'd0, frame_err}, 0);
        rst_n = 1'b1;
        tick(10);

        run_frame("freq1000", 8'h01, 32'd1000, 8'hEA);
        run_frame("enable",   8'h03, 32'd1,    8'h02);
        run_frame("duty50",   8'h02, 32'd50,   8'h30);
        run_frame("duty101",  8'h02, 32'd101,  8'h67);
        run_frame("badchk",   8'h01, 32'd1000, 8'h00);

        ok0 = n_ok; err0 = n_err;
        send_byte(8'h33, 1'b1);
        send_byte(8'h5A, 1'b1);
        tick(40);
        check("junk.frame_err", n_err - err0, 0);
        check("junk.cfg_ok", n_ok - ok0, 0);

        ok0 = n_ok; err0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hE8, 1'b1);
        tick(41 * BITC + 40);
        check("timeout.frame_err", n_err - err0, 1);
        check("timeout.cfg_ok", n_ok - ok0, 0);
        run_frame("after_tmo", 8'h01, 32'd2000, xsum(8'h01, 32'd2000));

        ok0 = n_ok; err0 = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hE8, 1'b0);
        tick(40);
        check("stopbit.frame_err", n_err - err0, 1);
        check("stopbit.cfg_ok", n_ok - ok0, 0);
        check_outputs("stopbit");
        run_frame("after_stop", 8'h02, 32'd100, xsum(8'h02, 32'd100));

        run_frame("fmax",   8'h01, FMAX,         xsum(8'h01, FMAX));
        run_frame("fmax1",  8'h01, FMAX + 1,     xsum(8'h01, FMAX + 1));
        run_frame("fzero",  8'h01, 32'd0,        xsum(8'h01, 32'd0));
        run_frame("fone",   8'h01, 32'd1,        xsum(8'h01, 32'd1));
        run_frame("dhigh",  8'h02, 32'hFFFF_FF07, xsum(8'h02, 32'hFFFF_FF07));
        run_frame("en_again", 8'h03, 32'h0000_00FF, xsum(8'h03, 32'h0000_00FF));
        run_frame("badcmd", 8'h04, 32'd10,       xsum(8'h04, 32'd10));

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    cmd = 8'h01;
                    case ($urandom_range(0, 3))
                        0: p = 32'($urandom_range(1, FMAX));
                        1: p = 32'd0;
                        2: p = FMAX + 32'($urandom_range(1, 1000));
                        default: p = 32'($urandom);
                    endcase
                end
                1: begin
                    cmd = 8'h02;
                    p = {24'($urandom), 8'($urandom_range(0, 120))};
                end
                2: begin
                    cmd = 8'h03;
                    p = 32'($urandom);
                end
                default: begin
                    cmd = 8'($urandom_range(4, 255));
                    p = 32'($urandom);
                end
            endcase
            chk = xsum(cmd, p);
            if ($urandom_range(0, 5) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", i), cmd, p, chk);
        end

        run_frame("pre_rst_en",   8'h03, 32'd1,  8'h02);
        run_frame("pre_rst_duty", 8'h02, 32'd77, xsum(8'h02, 32'd77));
        uart_rx = 1'b0;
        tick(3 * BITC);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_en = 1'b0; m_freq = DEF_FREQ; m_duty = 8'd0;
        check_outputs("async_rst");
        check("async_rst.cfg_ok", {31'd0, cfg_ok}, 0);
        check("async_rst.frame_err", {31'd0, frame_err}, 0);
        uart_rx = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(20);
        run_frame("after_rst", 8'h01, 32'd4321, xsum(8'h01, 32'd4321));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
